alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 39 +++
 rtl/alu_issue_ctrl_imm_ext.sv | 21 ++
 rtl/alu_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: ALU op selects, opcode
// constants, FSM states and the immediate-extension rule.
package alu_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_NOT     = 4'd0,
    ALU_ADD     = 4'd1,
    ALU_SUB     = 4'd2,
    ALU_SLT     = 4'd3,
    ALU_AND     = 4'd4,
    ALU_OR      = 4'd5,
    ALU_XOR     = 4'd6,
    ALU_NOR     = 4'd7,
    ALU_SLL     = 4'd8,
    ALU_SRL     = 4'd9,
    ALU_SRA     = 4'd10,
    ALU_ROL     = 4'd11,
    ALU_ROR     = 4'd12,
    ALU_MIN     = 4'd13,
    ALU_MAX     = 4'd14,
    ALU_HAMMING = 4'd15
  } alu_op_e;

  localparam logic [5:0] OPC_RTYPE     = 6'b000000;
  localparam logic [1:0] OPC_ITYPE_PFX = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  // Logical ops take an unsigned immediate; everything else is signed.
  function automatic logic imm_zero_ext(input logic [3:0] sel);
    return (sel >= ALU_AND) && (sel <= ALU_NOR);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_imm_ext.sv
// Extends the 16-bit instruction immediate to N bits, zero- or sign-
// extended depending on the selected ALU operation.
module alu_imm_ext
  import alu_issue_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [15:0]  imm16,
  input  logic [3:0]   alu_sel,
  output logic [N-1:0] imm
);

  always_comb begin
    if (imm_zero_ext(alu_sel)) begin
      imm = {{(N-16){1'b0}}, imm16};
    end else begin
      imm = {{(N-16){imm16[15]}}, imm16};
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU controller: accepts an instruction word, decodes it,
// drives the ALU for one cycle, captures the result and hands it to writeback.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [3:0]       alu_sel,
  output logic             b_imm_sel,
  output logic [N-1:0]     imm,
  input  logic [N-1:0]     alu_out,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [N-1:0]     wb_data,
  output logic [4:0]       rd_addr,
  output logic             rf_we,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e      state, state_nxt;
  logic [31:0] instr_q;
  logic [5:0]  opcode;
  logic        is_rtype;
  logic        is_itype;
  logic        legal;
  logic [4:0]  dest;

  // Decode works off the latched word, so the ALU controls stay stable
  // from DECODE through EXEC regardless of what instr does meanwhile.
  assign opcode   = instr_q[31:26];
  assign is_rtype = (opcode == OPC_RTYPE);
  assign is_itype = (opcode[5:4] == OPC_ITYPE_PFX);
  assign legal    = is_rtype | is_itype;
  assign rs_addr  = instr_q[25:21];
  assign rt_addr  = instr_q[20:16];

  always_comb begin
    alu_sel   = '0;
    b_imm_sel = 1'b0;
    dest      = '0;
    if (is_rtype) begin
      alu_sel = instr_q[3:0];
      dest    = instr_q[15:11];
    end else if (is_itype) begin
      alu_sel   = opcode[3:0];
      b_imm_sel = 1'b1;
      dest      = instr_q[20:16];
    end
  end

  alu_imm_ext #(.N(N)) u_imm_ext (
    .imm16   (instr_q[15:0]),
    .alu_sel (alu_sel),
    .imm     (imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    instr_ready  = 1'b0;
    result_valid = 1'b0;
    illegal      = 1'b0;
    case (state)
      ST_IDLE: begin
        // Held low while reset is asserted even though the state is IDLE.
        instr_ready = rst_n;
        if (instr_valid && instr_ready) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (legal) begin
          state_nxt = ST_EXEC;
        end else begin
          illegal   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt = ST_WB;
      ST_WB: begin
        result_valid = 1'b1;
        if (result_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rf_we = result_valid & result_ready & (rd_addr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      wb_data <= '0;
      rd_addr <= '0;
      retired <= '0;
    end else begin
      if (state == ST_IDLE && instr_valid) instr_q <= instr;
      if (state == ST_EXEC) begin
        wb_data <= alu_out;
        rd_addr <= dest;
      end
      if (state == ST_WB && result_ready) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed and random instructions
// checked against a behavioural decode/retire model.
module tb_alu_issue_ctrl;

  localparam int TB_CNT_W = 8;
  localparam int unsigned RET_MOD = 1 << TB_CNT_W;

  logic                clk;
  logic                rst_n;
  logic                instr_valid;
  logic [31:0]         instr;
  logic                instr_ready;
  logic [4:0]          rs_addr;
  logic [4:0]          rt_addr;
  logic [3:0]          alu_sel;
  logic                b_imm_sel;
  logic [31:0]         imm;
  logic [31:0]         alu_out;
  logic                result_valid;
  logic                result_ready;
  logic [31:0]         wb_data;
  logic [4:0]          rd_addr;
  logic                rf_we;
  logic                illegal;
  logic [TB_CNT_W-1:0] retired;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned exp_ret    = 0;

  alu_issue_ctrl #(.N(32), .CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .alu_sel      (alu_sel),
    .b_imm_sel    (b_imm_sel),
    .imm          (imm),
    .alu_out      (alu_out),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .wb_data      (wb_data),
    .rd_addr      (rd_addr),
    .rf_we        (rf_we),
    .illegal      (illegal),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the instruction-format rules.
  task automatic ref_decode(input logic [31:0] w, output bit legal, output logic [3:0] sel,
                            output logic bsel, output logic [31:0] immv, output logic [4:0] dst);
    int unsigned op;
    bit zx;
    op    = int'(w >> 26);
    legal = (op == 0) || (op >= 16 && op <= 31);
    if (op == 0) begin
      sel  = 4'(w % 16);
      bsel = 1'b0;
      dst  = 5'((w >> 11) % 32);
    end else begin
      sel  = 4'(op % 16);
      bsel = 1'b1;
      dst  = 5'((w >> 16) % 32);
    end
    zx   = (sel >= 4) && (sel <= 7);
    immv = w % 65536;
    if (!zx && immv >= 32768) immv = immv + 32'hFFFF0000;
  endtask

  // Called just after a falling edge with the DUT idle.
  task automatic run_instr(input logic [31:0] w, input int unsigned hold, input logic [31:0] res);
    bit          legal;
    logic [3:0]  sel;
    logic        bsel;
    logic [31:0] immv;
    logic [4:0]  dst;
    ref_decode(w, legal, sel, bsel, immv, dst);

    chk("ready_idle", instr_ready, 1);
    instr_valid  = 1'b1;
    instr        = w;
    alu_out      = $urandom;
    result_ready = 1'b0;

    @(negedge clk);
    instr_valid  = 1'($urandom_range(0, 1));
    instr        = $urandom;
    result_ready = 1'($urandom_range(0, 1));
    #1;
    chk("ready_decode", instr_ready, 0);
    chk("illegal_decode", illegal, legal ? 0 : 1);
    chk("rs_decode", rs_addr, (w >> 21) % 32);
    chk("rt_decode", rt_addr, (w >> 16) % 32);
    chk("rf_we_decode", rf_we, 0);
    if (!legal) begin
      chk("valid_illegal", result_valid, 0);
      instr_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("illegal_drop", illegal, 0);
      chk("ready_after_illegal", instr_ready, 1);
      chk("valid_after_illegal", result_valid, 0);
      chk("retired_illegal", retired, exp_ret);
      result_ready = 1'b0;
      return;
    end
    chk("alu_sel_decode", alu_sel, sel);
    chk("bsel_decode", b_imm_sel, bsel);
    chk("imm_decode", imm, immv);
    alu_out = res;

    @(negedge clk);
    #1;
    chk("alu_sel_exec", alu_sel, sel);
    chk("bsel_exec", b_imm_sel, bsel);
    chk("imm_exec", imm, immv);
    chk("rs_exec", rs_addr, (w >> 21) % 32);
    chk("valid_exec", result_valid, 0);
    chk("rf_we_exec", rf_we, 0);

    @(negedge clk);
    alu_out      = $urandom;
    instr_valid  = 1'b0;
    result_ready = 1'b0;
    for (int unsigned i = 0; i < hold; i++) begin
      #1;
      chk("valid_hold", result_valid, 1);
      chk("wb_data_hold", wb_data, res);
      chk("rd_addr_hold", rd_addr, dst);
      chk("rf_we_hold", rf_we, 0);
      chk("ready_hold", instr_ready, 0);
      @(negedge clk);
    end
    result_ready = 1'b1;
    #1;
    chk("valid_accept", result_valid, 1);
    chk("wb_data_accept", wb_data, res);
    chk("rd_addr_accept", rd_addr, dst);
    chk("rf_we_accept", rf_we, (dst != 0) ? 1 : 0);

    @(negedge clk);
    result_ready = 1'b0;
    exp_ret = (exp_ret + 1) % RET_MOD;
    #1;
    chk("retired", retired, exp_ret);
    chk("valid_after", result_valid, 0);
    chk("ready_after", instr_ready, 1);
    chk("rf_we_after", rf_we, 0);
  endtask

  initial begin
    logic [31:0] w;
    instr_valid  = 1'b0;
    instr        = '0;
    alu_out      = '0;
    result_ready = 1'b0;
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", instr_ready, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_bsel", b_imm_sel, 0);
    chk("rst_imm", imm, 0);
    chk("rst_rs", rs_addr, 0);
    chk("rst_rt", rt_addr, 0);
    chk("rst_rd", rd_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_retired", retired, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_post_rst", instr_ready, 1);
    @(negedge clk);

    // R-type add rs=1 rt=2 rd=3, result 7
    run_instr({6'b000000, 5'd1, 5'd2, 5'd3, 11'h001}, 0, 32'd7);
    // I-type AND and SUB with imm16 = FFFF
    run_instr({6'b010100, 5'd4, 5'd5, 16'hFFFF}, 0, $urandom);
    chk("imm_and_ffff_const", imm, 32'h0000FFFF);
    run_instr({6'b010010, 5'd6, 5'd7, 16'hFFFF}, 1, $urandom);
    chk("imm_sub_ffff_const", imm, 32'hFFFFFFFF);
    // Illegal opcode
    run_instr({6'b110000, 26'h1234567}, 0, $urandom);
    // Long backpressure
    run_instr({6'b000000, 5'd8, 5'd9, 5'd10, 11'h002}, 5, $urandom);
    // Destination 0
    run_instr({6'b000000, 5'd1, 5'd2, 5'd0, 11'h001}, 0, $urandom);
    run_instr({6'b011001, 5'd3, 5'd0, 16'h8000}, 2, $urandom);

    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      case ($urandom_range(0, 2))
        0: w[31:26] = 6'b000000;
        1: w[31:30] = 2'b01;
        default: ;
      endcase
      run_instr(w, $urandom_range(0, 3), $urandom);
    end

    // Drive the retired counter around to its wrap point
    begin
      int unsigned n;
      n = RET_MOD - exp_ret;
      for (int unsigned i = 0; i < n; i++) begin
        w = $urandom;
        w[31:26] = 6'b000000;
        run_instr(w, 0, $urandom);
      end
      chk("retired_wrapped", retired, 0);
    end

    // Reset while the instruction is in EXEC
    instr_valid = 1'b1;
    instr       = {6'b000000, 5'd1, 5'd2, 5'd5, 11'h001};
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    result_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_exec_ready", instr_ready, 0);
    chk("rst_exec_valid", result_valid, 0);
    chk("rst_exec_rf_we", rf_we, 0);
    chk("rst_exec_retired", retired, 0);
    chk("rst_exec_wb_data", wb_data, 0);
    chk("rst_exec_rd", rd_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_valid", result_valid, 0);
      chk("post_rst_rf_we", rf_we, 0);
      chk("post_rst_ready", instr_ready, 1);
      chk("post_rst_retired", retired, exp_ret);
      @(negedge clk);
    end
    result_ready = 1'b0;
    run_instr({6'b010001, 5'd2, 5'd9, 16'h0042}, 1, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
